// File: rtl/adler32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adler32_arbiter
// Brief    : Round-robin packet arbiter sharing one adler32 engine between
//            NUM_REQ byte streams; returns tagged checksums on a result port.
//            Define ADLER_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module adler32_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 eng_data_valid,
  output logic [7:0]           eng_data,
  output logic                 eng_last_data,
  input  logic                 eng_checksum_valid,
  input  logic [31:0]          eng_checksum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [31:0]          res_checksum,
  output logic [15:0]          res_len,
  output logic                 res_timeout,
  output logic                 busy
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_stream = 2'd1;
  localparam logic [1:0] c_wait   = 2'd2;
  localparam logic [1:0] c_result = 2'd3;
  localparam logic [ID_W-1:0] c_last_init = ID_W'(NUM_REQ - 1);

  generate
    if (((2 ** ID_W) < NUM_REQ) || (NUM_REQ < 1) || (TIMEOUT < 1)) begin : g_bad_cfg
      $error("adler32_arbiter: illegal NUM_REQ/ID_W/TIMEOUT combination");
    end
  endgenerate

  logic [1:0]      r_state, w_next;
  logic [ID_W-1:0] r_grant, r_last_grant, w_pick;
  logic            w_any, w_xfer, w_cur_last, w_tmo_hit;
  logic [7:0]      w_cur_data;
  logic [15:0]     r_count;
  logic            r_eng_valid, r_eng_last;
  logic [7:0]      r_eng_data;
  logic [ID_W-1:0] r_res_id;
  logic [31:0]     r_res_chk;
  logic [15:0]     r_res_len;

  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan downwards so the nearest requester after last_grant is written last.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[f_wrap(r_last_grant, k)]) begin
        w_pick = f_wrap(r_last_grant, k);
        w_any  = 1'b1;
      end
    end
  end

  assign w_xfer     = (r_state == c_stream) && req_valid[r_grant];
  assign w_cur_last = req_last[r_grant];
  assign w_cur_data = req_data[{r_grant, 3'b000} +: 8];

  always_ff @(posedge clock) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:   if (w_any) w_next = c_stream;
      c_stream: if (w_xfer && w_cur_last) w_next = c_wait;
      c_wait:   if (eng_checksum_valid || w_tmo_hit) w_next = c_result;
      c_result: if (res_ready) w_next = c_idle;
      default:  w_next = c_idle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (r_state == c_stream) req_ready[r_grant] = 1'b1;
    res_valid = (r_state == c_result);
    busy      = (r_state != c_idle);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= c_last_init;
      r_count      <= '0;
      r_eng_valid  <= 1'b0;
      r_eng_data   <= '0;
      r_eng_last   <= 1'b0;
      r_res_id     <= '0;
      r_res_chk    <= '0;
      r_res_len    <= '0;
    end else begin
      r_eng_valid <= w_xfer;
      r_eng_data  <= w_xfer ? w_cur_data : 8'h00;
      r_eng_last  <= w_xfer & w_cur_last;
      if ((r_state == c_idle) && w_any) r_grant <= w_pick;
      if (w_xfer && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
      // A real checksum wins over a timeout landing in the same cycle.
      if (r_state == c_wait) begin
        if (eng_checksum_valid) begin
          r_res_id  <= r_grant;
          r_res_chk <= eng_checksum;
          r_res_len <= r_count;
        end else if (w_tmo_hit) begin
          r_res_id  <= r_grant;
          r_res_chk <= '0;
          r_res_len <= r_count;
        end
      end
      if ((r_state == c_result) && res_ready) begin
        r_last_grant <= r_grant;
        r_count      <= '0;
      end
    end
  end

`ifdef ADLER_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  logic [c_tmo_w-1:0] r_wait_cnt;
  logic               r_res_tmo;

  always_ff @(posedge clock) begin
    if (rst || (r_state != c_wait)) r_wait_cnt <= '0;
    else                            r_wait_cnt <= r_wait_cnt + c_tmo_w'(1);
  end

  always_ff @(posedge clock) begin
    if (rst)                                           r_res_tmo <= 1'b0;
    else if ((r_state == c_wait) && eng_checksum_valid) r_res_tmo <= 1'b0;
    else if (w_tmo_hit)                                 r_res_tmo <= 1'b1;
  end

  assign w_tmo_hit   = (r_state == c_wait) && (r_wait_cnt == c_tmo_w'(TIMEOUT - 1));
  assign res_timeout = r_res_tmo;
`else
  assign w_tmo_hit   = 1'b0;
  assign res_timeout = 1'b0;
`endif

  assign eng_data_valid = r_eng_valid;
  assign eng_data       = r_eng_data;
  assign eng_last_data  = r_eng_last;
  assign res_id         = r_res_id;
  assign res_checksum   = r_res_chk;
  assign res_len        = r_res_len;

endmodule
`default_nettype wire

// File: doc/adler32_arbiter.md
Name: adler32_arbiter

Overview:
- Packet-level arbiter and sequencer that shares one adler32 checksum engine between NUM_REQ byte-stream requesters.
- Grants one requester per packet using round-robin, and forwards its bytes to the engine with a registered interface.
- Waits for the engine's checksum, then returns it tagged with requester ID and packet length on a valid/ready result port.
- Sits between the packet sources and the single checksum engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 32, max cycles in WAIT before abort (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet.
- req_ready  out  NUM_REQ  byte accepted when valid&ready.
- eng_data_valid  out  1  byte strobe to engine.
- eng_data  out  8  byte to engine.
- eng_last_data  out  1  last-byte flag to engine.
- eng_checksum_valid  in  1  engine result strobe.
- eng_checksum  in  32  engine result {B,A}.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_id  out  ID_W  requester index of the result.
- res_checksum  out  32  captured checksum.
- res_len  out  16  bytes in packet, saturating at 0xFFFF.
- res_timeout  out  1  result aborted by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE -> STREAM -> WAIT -> RESULT -> IDLE.
- Reset (sync, dominates all other events, including mid-packet):
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - byte counter=0; the engine is not separately reset by this block.
- IDLE:
  - req_ready=0.
  - If any req_valid is high, pick the first set bit searching from last_grant+1 with wrap-around; register it as grant and move to STREAM next cycle.
- STREAM:
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - On each transfer, eng_data_valid/eng_data/eng_last_data are registered copies of the requester inputs, so the engine sees the byte exactly 1 cycle later. Otherwise eng_data_valid=0.
  - Byte counter increments per transfer and saturates at 0xFFFF.
  - Transfer with req_last=1 -> WAIT. Back-to-back bytes are accepted at 1 byte/cycle.
- WAIT:
  - eng_* outputs are 0 after the final registered byte drains.
  - On eng_checksum_valid, capture eng_checksum, res_len and res_id=grant, then go to RESULT.
- RESULT:
  - res_valid=1; res_* fields are held stable until res_valid&res_ready.
  - On that handshake: last_grant=grant, counter=0, go to IDLE.
  - Earliest next grant is 1 cycle later, so there are at least 2 cycles between packets.
- eng_checksum_valid in any state other than WAIT is ignored.
- A requester dropping req_valid mid-packet keeps the grant; the arbiter waits indefinitely in STREAM.
- A requester asserting req_valid outside its grant sees req_ready=0 and must hold its data.
- NUM_REQ=1 degenerates to grant=0 always.

Optional Feature:
- Macro: ADLER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles pass without eng_checksum_valid, go to RESULT with res_checksum=0 and res_timeout=1.
  - A late eng_checksum_valid after the abort is ignored.
- Undefined: no counter; WAIT waits forever; res_timeout is tied to 0.

Test Plan:
- Reset, then req0 sends "a" (0x61, last): eng_data_valid 1 cycle after accept; with the behavioural engine, res_valid gives res_id=0, res_checksum=0x00620062, res_len=1.
- Req1 sends "abc" back-to-back: req_ready[1] high for 3 cycles; res_checksum=0x024D0127, res_len=3.
- Req0 and req2 both hold valid in IDLE after reset: req0 granted first. Req2 must see req_ready=0 until req0's result handshake, then is granted; req0 re-requesting loses to req2.
- Req3 sends "Wikipedia" with req_valid gaps mid-packet; res_ready held low 5 cycles: res_checksum=0x11E60398, res_len=9, fields stable throughout the stall.
- Assert rst during STREAM of req2: next cycle state=IDLE, busy=0, all ready=0; the next grant goes to the lowest-index valid requester.
- With ADLER_TIMEOUT_EN and TIMEOUT=32, the engine never responds: res_valid occurs 32 cycles after entering WAIT with res_timeout=1 and res_checksum=0; without the macro, busy stays 1.
